// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg: shared AHB encodings and helpers for the multi-master arbiter.
//   htrans_e  : transfer type codes (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_e  : burst type codes (SINGLE..INCR16)
//   hresp_e   : slave response codes (OKAY/ERROR/RETRY/SPLIT)
//   burst_len : beats in a defined-length burst (undefined INCR counts as 1)
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  // Undefined-length INCR is treated as single beats so it can be re-arbitrated.
  function automatic logic [CNT_W-1:0] burst_len(input logic [2:0] hburst);
    logic [CNT_W-1:0] len;
    len = CNT_W'(1);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  len = CNT_W'(4);
      HBURST_WRAP8,  HBURST_INCR8:  len = CNT_W'(8);
      HBURST_WRAP16, HBURST_INCR16: len = CNT_W'(16);
      default:                      len = CNT_W'(1);
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_arb_if.sv
// ---------------------------------------------------------------------------
// ahb_arb_if: bundle of master-side and decoder-side AHB signals around the
// arbiter. Per-master fields are packed, master i at slice [W*i +: W].
//   modport slave  : the arbiter's view (masters + decoder response in,
//                    grants, muxed address/data and broadcast response out)
//   modport master : the environment's view (masters and the decoder)
// ---------------------------------------------------------------------------
interface ahb_arb_if #(
  parameter int unsigned NUM_M = 3
);
  localparam int unsigned MW = $clog2(NUM_M);

  // Per-master request side
  logic [NUM_M-1:0]    m_hbusreq;
  logic [NUM_M-1:0]    m_hlock;
  logic [NUM_M*32-1:0] m_haddr;
  logic [NUM_M*2-1:0]  m_htrans;
  logic [NUM_M-1:0]    m_hwrite;
  logic [NUM_M*3-1:0]  m_hsize;
  logic [NUM_M*3-1:0]  m_hburst;
  logic [NUM_M*4-1:0]  m_hprot;
  logic [NUM_M*32-1:0] m_hwdata;

  // Arbitration results
  logic [NUM_M-1:0]    m_hgrant;
  logic [MW-1:0]       hmaster;
  logic                hmastlock;

  // Towards the decoder
  logic                s_hsel;
  logic [31:0]         s_haddr;
  logic [1:0]          s_htrans;
  logic                s_hwrite;
  logic [2:0]          s_hsize;
  logic [2:0]          s_hburst;
  logic [3:0]          s_hprot;
  logic [31:0]         s_hwdata;
  logic                s_hready_in;

  // Decoder response and its broadcast
  logic [31:0]         s_hrdata;
  logic                s_hready;
  logic [1:0]          s_hresp;
  logic [31:0]         m_hrdata;
  logic                m_hready;
  logic [1:0]          m_hresp;

  modport slave (
    input  m_hbusreq, m_hlock, m_haddr, m_htrans, m_hwrite, m_hsize,
           m_hburst, m_hprot, m_hwdata, s_hrdata, s_hready, s_hresp,
    output m_hgrant, hmaster, hmastlock, s_hsel, s_haddr, s_htrans,
           s_hwrite, s_hsize, s_hburst, s_hprot, s_hwdata, s_hready_in,
           m_hrdata, m_hready, m_hresp
  );

  modport master (
    output m_hbusreq, m_hlock, m_haddr, m_htrans, m_hwrite, m_hsize,
           m_hburst, m_hprot, m_hwdata, s_hrdata, s_hready, s_hresp,
    input  m_hgrant, hmaster, hmastlock, s_hsel, s_haddr, s_htrans,
           s_hwrite, s_hsize, s_hburst, s_hprot, s_hwdata, s_hready_in,
           m_hrdata, m_hready, m_hresp
  );

endinterface

// File: rtl/ahb_arb_rr.sv
// ---------------------------------------------------------------------------
// ahb_arb_rr: combinational rotating-priority search.
//   i_req   : per-master request vector
//   i_ptr   : index of the last granted master (lowest priority this round)
//   o_grant : one-hot selection
//   o_idx   : index of the selection; DEF_MASTER when nobody requests
// ---------------------------------------------------------------------------
module ahb_arb_rr #(
  parameter int unsigned NUM_M      = 3,
  parameter int unsigned DEF_MASTER = 0,
  parameter int unsigned MW         = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [MW-1:0]    i_ptr,
  output logic [NUM_M-1:0] o_grant,
  output logic [MW-1:0]    o_idx
);

  // Search ptr+1 .. ptr (mod NUM_M); the pointer itself is visited last.
  always_comb begin
    logic        w_found;
    int unsigned w_cand;
    w_found = 1'b0;
    w_cand  = 0;
    o_idx   = MW'(DEF_MASTER);
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      w_cand = (32'(i_ptr) + k) % NUM_M;
      if (!w_found && i_req[MW'(w_cand)]) begin
        w_found = 1'b1;
        o_idx   = MW'(w_cand);
      end
    end
    o_grant = NUM_M'(1) << o_idx;
  end

endmodule

// File: rtl/ahb_arb.sv
// ---------------------------------------------------------------------------
// ahb_arb: round-robin AHB arbiter sharing one decoder port between NUM_M
// masters. Defined-length bursts and locked sequences are never broken.
//   hclk, hresetn : bus clock, asynchronous active-low reset
//   bus (slave)   : per-master requests/address/data in; registered one-hot
//                   grant and hmaster out; address phase muxed by hmaster,
//                   write data muxed by the data-phase owner; decoder
//                   response broadcast back to every master.
// ---------------------------------------------------------------------------
module ahb_arb
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_M      = 3,
  parameter int unsigned DEF_MASTER = 0,
  parameter int unsigned MW         = $clog2(NUM_M)
) (
  input  logic     hclk,
  input  logic     hresetn,
  ahb_arb_if.slave bus
);

  localparam logic [NUM_M-1:0] GRANT_RST = NUM_M'(1) << DEF_MASTER;
  localparam logic [MW-1:0]    IDX_RST   = MW'(DEF_MASTER);

  logic [NUM_M-1:0] r_hgrant;
  logic [MW-1:0]    r_hmaster;
  logic [MW-1:0]    r_hmaster_d;
  logic [MW-1:0]    r_rr_ptr;
  logic [CNT_W-1:0] r_beat_cnt;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_arb_ok;
  logic [NUM_M-1:0] w_sel_oh;
  logic [MW-1:0]    w_sel_idx;

  // Unpacked per-master views of the packed buses
  logic [31:0] w_addr_a  [NUM_M];
  logic [1:0]  w_trans_a [NUM_M];
  logic [2:0]  w_size_a  [NUM_M];
  logic [2:0]  w_burst_a [NUM_M];
  logic [3:0]  w_prot_a  [NUM_M];
  logic [31:0] w_wdata_a [NUM_M];

  logic [1:0]  w_htrans;
  logic [2:0]  w_hburst;

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
    assign w_addr_a[gi]  = bus.m_haddr[32*gi +: 32];
    assign w_trans_a[gi] = bus.m_htrans[2*gi +: 2];
    assign w_size_a[gi]  = bus.m_hsize[3*gi +: 3];
    assign w_burst_a[gi] = bus.m_hburst[3*gi +: 3];
    assign w_prot_a[gi]  = bus.m_hprot[4*gi +: 4];
    assign w_wdata_a[gi] = bus.m_hwdata[32*gi +: 32];
  end

  // Address phase follows the current owner
  assign w_htrans      = w_trans_a[r_hmaster];
  assign w_hburst      = w_burst_a[r_hmaster];
  assign bus.s_haddr   = w_addr_a[r_hmaster];
  assign bus.s_htrans  = w_htrans;
  assign bus.s_hwrite  = bus.m_hwrite[r_hmaster];
  assign bus.s_hsize   = w_size_a[r_hmaster];
  assign bus.s_hburst  = w_hburst;
  assign bus.s_hprot   = w_prot_a[r_hmaster];
  assign bus.s_hsel    = 1'b1;

  // Write data follows the owner of the transfer currently in data phase
  assign bus.s_hwdata  = w_wdata_a[r_hmaster_d];

  assign bus.hmastlock = bus.m_hlock[r_hmaster] & (w_htrans != HTRANS_IDLE);

  // Response path is a straight broadcast
  assign bus.s_hready_in = bus.s_hready;
  assign bus.m_hrdata    = bus.s_hrdata;
  assign bus.m_hready    = bus.s_hready;
  assign bus.m_hresp     = bus.s_hresp;

  assign bus.m_hgrant  = r_hgrant;
  assign bus.hmaster   = r_hmaster;

  // Remaining beats after the current one; ERROR aborts the burst outright
  always_comb begin
    w_cnt_nxt = r_beat_cnt;
    if (bus.s_hresp == HRESP_ERROR) begin
      w_cnt_nxt = '0;
    end else if (bus.s_hready) begin
      if (w_htrans == HTRANS_NONSEQ) begin
        w_cnt_nxt = burst_len(w_hburst) - CNT_W'(1);
      end else if ((w_htrans == HTRANS_SEQ) && (r_beat_cnt != '0)) begin
        w_cnt_nxt = r_beat_cnt - CNT_W'(1);
      end else if ((w_htrans == HTRANS_IDLE) && (r_beat_cnt != '0)) begin
        w_cnt_nxt = '0;
      end
    end
  end

  // Re-arbitrate only at burst boundaries and outside a held lock
  assign w_arb_ok = bus.s_hready & (w_cnt_nxt == '0)
                  & ~(bus.m_hlock[r_hmaster] & bus.m_hbusreq[r_hmaster]);

  ahb_arb_rr #(
    .NUM_M      (NUM_M),
    .DEF_MASTER (DEF_MASTER),
    .MW         (MW)
  ) u_rr (
    .i_req   (bus.m_hbusreq),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_sel_oh),
    .o_idx   (w_sel_idx)
  );

  // Grant, owner, data-phase owner and burst tracking state
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_hgrant    <= GRANT_RST;
      r_hmaster   <= IDX_RST;
      r_hmaster_d <= IDX_RST;
      r_rr_ptr    <= IDX_RST;
      r_beat_cnt  <= '0;
    end else begin
      r_beat_cnt <= w_cnt_nxt;
      if (w_arb_ok) begin
        r_hgrant  <= w_sel_oh;
        r_hmaster <= w_sel_idx;
        r_rr_ptr  <= w_sel_idx;
      end
      if (bus.s_hready) begin
        r_hmaster_d <= r_hmaster;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arb.sv
// ---------------------------------------------------------------------------
// tb_ahb_arb: self-checking bench for ahb_arb (NUM_M=3, DEF_MASTER=0).
// Expected ownership changes (owner, cycle) are queued as stimulus is driven
// and popped by a monitor whenever hmaster changes.
// ---------------------------------------------------------------------------
module tb_ahb_arb;
  import ahb_pkg::*;

  localparam int unsigned NM = 3;

  typedef struct {
    int owner;
    int cyc;
  } gexp_t;

  logic hclk = 1'b0;
  logic hresetn;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  gexp_t sb[$];
  gexp_t mon_e;
  logic [1:0] prev_hm = 2'd0;

  ahb_arb_if #(.NUM_M(NM)) bus ();

  ahb_arb #(
    .NUM_M      (NM),
    .DEF_MASTER (0)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus.slave)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return 32'hA000_0000 | (32'(i) << 8);
  endfunction

  function automatic logic [31:0] wd_of(input int i);
    return 32'hD000_0000 | 32'(i);
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input int o, input int c);
    gexp_t e;
    e.owner = o;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  task automatic set_m(input int i, input logic req, input logic lock,
                       input logic [1:0] tr, input logic [2:0] bu);
    bus.m_hbusreq[i]        = req;
    bus.m_hlock[i]          = lock;
    bus.m_htrans[2*i +: 2]  = tr;
    bus.m_hburst[3*i +: 3]  = bu;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NM; i++) set_m(i, 1'b0, 1'b0, HTRANS_IDLE, HBURST_SINGLE);
  endtask

  // INCR4 by m1 with m2 requesting from beat 2; optional wait states on beat 3
  task automatic run_incr4(input int waits);
    int b;
    b = cyc;
    set_m(1, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_INCR4);
    set_m(2, 1'b0, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    push(1, b + 1);
    push(2, b + 5 + waits);
    push(0, b + 6 + waits);
    tick();                                   // b+1: m1 granted
    tick();                                   // b+2: NONSEQ accepted
    set_m(1, 1'b0, 1'b0, HTRANS_SEQ, HBURST_INCR4);
    set_m(2, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    tick();                                   // b+3: beat 2 accepted
    tick();                                   // b+4: beat 3 accepted
    if (waits > 0) begin
      bus.s_hready = 1'b0;
      for (int w = 0; w < waits; w++) begin
        tick();
        chk("wait_m_hready", 32'(bus.m_hready), 32'd0);
      end
      chk("wait_hwdata_hold", bus.s_hwdata, wd_of(1));
      bus.s_hready = 1'b1;
    end
    tick();                                   // beat 4 accepted, m2 granted
    chk("burst_hwdata_lag", bus.s_hwdata, wd_of(1));
    idle_all();
    tick();                                   // back to parked m0
    chk("burst_hwdata_m2", bus.s_hwdata, wd_of(2));
  endtask

  // Ownership monitor: each change must match the next queued expectation
  always @(negedge hclk) begin
    if (bus.hmaster !== prev_hm) begin
      if (sb.size() == 0) begin
        chk("unexp_owner", 32'(bus.hmaster), 32'(prev_hm));
      end else begin
        mon_e = sb.pop_front();
        chk("owner", 32'(bus.hmaster), 32'(mon_e.owner));
        chk("owner_cyc", 32'(cyc), 32'(mon_e.cyc));
        chk("grant_onehot", 32'(bus.m_hgrant), 32'd1 << mon_e.owner);
      end
      prev_hm = bus.hmaster;
    end
  end

  initial begin
    int b;
    hresetn = 1'b1;
    idle_all();
    for (int i = 0; i < NM; i++) begin
      bus.m_haddr[32*i +: 32]  = addr_of(i);
      bus.m_hwdata[32*i +: 32] = wd_of(i);
      bus.m_hsize[3*i +: 3]    = 3'b010;
      bus.m_hprot[4*i +: 4]    = 4'(i + 4);
    end
    bus.m_hwrite = 3'b010;
    bus.s_hrdata = 32'h1234_5678;
    bus.s_hready = 1'b1;
    bus.s_hresp  = HRESP_OKAY;
    set_m(0, 1'b0, 1'b0, HTRANS_BUSY, HBURST_SINGLE);
    #1 hresetn = 1'b0;
    @(posedge hclk);
    @(posedge hclk);
    #1 hresetn = 1'b1;

    // 1: reset state and parking
    #1;
    chk("rst_grant", 32'(bus.m_hgrant), 32'b001);
    chk("rst_hmaster", 32'(bus.hmaster), 32'd0);
    chk("rst_haddr", bus.s_haddr, addr_of(0));
    chk("rst_htrans", 32'(bus.s_htrans), 32'(HTRANS_BUSY));
    chk("rst_hwdata", bus.s_hwdata, wd_of(0));
    chk("hsel", 32'(bus.s_hsel), 32'd1);
    chk("hready_in", 32'(bus.s_hready_in), 32'd1);
    chk("hrdata_bcast", bus.m_hrdata, 32'h1234_5678);
    chk("hresp_bcast", 32'(bus.m_hresp), 32'(HRESP_OKAY));
    repeat (10) tick();
    chk("park_grant", 32'(bus.m_hgrant), 32'b001);
    idle_all();
    tick();

    // 2: m1/m2 alternate on SINGLE transfers
    b = cyc;
    set_m(1, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    set_m(2, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    push(1, b + 1);
    push(2, b + 2);
    push(1, b + 3);
    push(2, b + 4);
    push(0, b + 5);
    tick();
    tick();
    chk("rr_haddr", bus.s_haddr, addr_of(2));
    chk("rr_hprot", 32'(bus.s_hprot), 32'd6);
    chk("rr_hwrite", 32'(bus.s_hwrite), 32'd0);
    chk("rr_hwdata_lag1", bus.s_hwdata, wd_of(1));
    tick();
    chk("rr_hwrite_m1", 32'(bus.s_hwrite), 32'd1);
    chk("rr_hwdata_lag2", bus.s_hwdata, wd_of(2));
    tick();
    idle_all();
    tick();
    tick();

    // 3/4: no switch inside a defined-length burst, with and without waits
    run_incr4(0);
    tick();
    run_incr4(2);
    tick();

    // 5: locked sequence
    b = cyc;
    set_m(0, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
    set_m(1, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    push(1, b + 3);
    push(0, b + 4);
    tick();
    chk("lock_hmastlock1", 32'(bus.hmastlock), 32'd1);
    tick();
    chk("lock_hmastlock2", 32'(bus.hmastlock), 32'd1);
    set_m(0, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    #1;
    chk("unlock_hmastlock", 32'(bus.hmastlock), 32'd0);
    tick();
    idle_all();
    tick();
    tick();

    // 6a: ERROR mid INCR8 ends the burst
    b = cyc;
    set_m(1, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_INCR8);
    set_m(2, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    push(1, b + 1);
    push(2, b + 5);
    push(0, b + 6);
    tick();
    tick();
    set_m(1, 1'b1, 1'b0, HTRANS_SEQ, HBURST_INCR8);
    tick();
    bus.s_hready = 1'b0;
    bus.s_hresp  = HRESP_ERROR;
    tick();
    bus.s_hready = 1'b1;
    #1;
    chk("err_hresp_bcast", 32'(bus.m_hresp), 32'(HRESP_ERROR));
    tick();
    bus.s_hresp = HRESP_OKAY;
    idle_all();
    tick();
    tick();

    // 6b: reset mid-burst, then pointer/counter back at reset values
    b = cyc;
    set_m(1, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_INCR4);
    push(1, b + 1);
    push(0, b + 3);
    tick();
    tick();
    set_m(1, 1'b1, 1'b0, HTRANS_SEQ, HBURST_INCR4);
    tick();
    hresetn = 1'b0;
    #1;
    chk("midrst_grant", 32'(bus.m_hgrant), 32'b001);
    chk("midrst_hmaster", 32'(bus.hmaster), 32'd0);
    chk("midrst_haddr", bus.s_haddr, addr_of(0));
    chk("midrst_hwdata", bus.s_hwdata, wd_of(0));
    idle_all();
    tick();
    hresetn = 1'b1;
    set_m(1, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    set_m(2, 1'b1, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    push(1, b + 5);
    push(0, b + 6);
    tick();
    idle_all();
    tick();
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
